// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and divider step count for the mul/div sequencer.
package muldiv_pkg;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MUL     = 3'd1;
  localparam logic [2:0] ST_DIV_RUN = 3'd2;
  localparam logic [2:0] ST_DIV_FIX = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    MUL     = ST_MUL,
    DIV_RUN = ST_DIV_RUN,
    DIV_FIX = ST_DIV_FIX,
    DONE    = ST_DONE
  } md_state_e;

  localparam int DIV_STEPS = 32;
endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Iterative restoring divider datapath: one quotient bit per step, unsigned operands.
module div_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_o
);
  localparam int CW = $clog2(DIV_STEPS);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH+1:0] trial;

  // Shifted partial remainder can reach WIDTH+1 bits; one extra bit holds the sign.
  always_comb begin
    trial = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
    if (!trial[WIDTH+1]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quot_o = quo_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == CW'(DIV_STEPS - 1));
endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS mul/div sequencer: stalls the pipe until HI/LO is ready, then pulses md_valid.
// Optional MULDIV_STALL_CNT_EN adds a saturating stall-cycle counter output.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_start,
  input  logic [1:0]       ex_op,
  input  logic [WIDTH-1:0] ex_rs_data,
  input  logic [WIDTH-1:0] ex_rt_data,
  input  logic             flush,
  output logic             stall_req,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo,
  output logic             div_by_zero
`ifdef MULDIV_STALL_CNT_EN
  ,
  output logic [31:0]      md_stall_cnt
`endif
);
  md_state_e        state_q, state_d;
  logic [1:0]       mcnt_q, mcnt_d, op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, hi_q, hi_d, lo_q, lo_d;
  logic             qn_q, qn_d, rn_q, rn_d, dz_q, dz_d;
  logic             in_sgn, div_load, div_step, div_last;
  logic [WIDTH-1:0] dvd_in, dvs_in, quot, rem;
  logic signed [WIDTH:0]     ma, mb;
  logic signed [2*WIDTH+1:0] prod;

  assign in_sgn = ~ex_op[0];
  assign dvd_in = (in_sgn && ex_rs_data[WIDTH-1]) ? -ex_rs_data : ex_rs_data;
  assign dvs_in = (in_sgn && ex_rt_data[WIDTH-1]) ? -ex_rt_data : ex_rt_data;

  assign ma   = {(op_q == MD_MULT) & rs_q[WIDTH-1], rs_q};
  assign mb   = {(op_q == MD_MULT) & rt_q[WIDTH-1], rt_q};
  assign prod = ma * mb;

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (dvd_in),
    .divisor_i  (dvs_in),
    .quot_o     (quot),
    .rem_o      (rem),
    .last_o     (div_last)
  );

  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    qn_d     = qn_q;
    rn_d     = rn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    div_load = 1'b0;
    div_step = 1'b0;
    if (flush) begin
      state_d = IDLE;
      dz_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ex_start) begin
          op_d = ex_op;
          rs_d = ex_rs_data;
          rt_d = ex_rt_data;
          qn_d = in_sgn & (ex_rs_data[WIDTH-1] ^ ex_rt_data[WIDTH-1]);
          rn_d = in_sgn & ex_rs_data[WIDTH-1];
          dz_d = 1'b0;
          if (!ex_op[1]) begin
            state_d = MUL;
            mcnt_d  = 2'(MUL_LATENCY - 1);
          end else if (ex_rt_data == '0) begin
            state_d = DONE;
            hi_d    = ex_rs_data;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d  = DIV_RUN;
            div_load = 1'b1;
          end
        end
        MUL: begin
          if (mcnt_q == 2'd0) begin
            hi_d    = prod[2*WIDTH-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
            state_d = DONE;
          end else begin
            mcnt_d = mcnt_q - 2'd1;
          end
        end
        DIV_RUN: begin
          div_step = 1'b1;
          if (div_last) state_d = DIV_FIX;
        end
        DIV_FIX: begin
          lo_d    = qn_q ? -quot : quot;
          hi_d    = rn_q ? -rem : rem;
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcnt_q  <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      qn_q    <= 1'b0;
      rn_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      qn_q    <= qn_d;
      rn_q    <= rn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign stall_req   = ((state_q == IDLE) && ex_start && !flush) ||
                       (state_q == MUL) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign md_valid    = (state_q == DONE) && !flush;
  assign md_hi       = hi_q;
  assign md_lo       = lo_q;
  assign div_by_zero = dz_q;

`ifdef MULDIV_STALL_CNT_EN
  logic [31:0] scnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scnt_q <= '0;
    else if (stall_req && (scnt_q != 32'hFFFF_FFFF)) scnt_q <= scnt_q + 32'd1;
  end
  assign md_stall_cnt = scnt_q;
`endif
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int ML = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_start = 1'b0;
  logic [1:0]  ex_op = 2'b00;
  logic [31:0] ex_rs_data = '0, ex_rt_data = '0;
  logic        flush = 1'b0;
  logic        stall_req, md_valid, div_by_zero;
  logic [31:0] md_hi, md_lo;
`ifdef MULDIV_STALL_CNT_EN
  logic [31:0] md_stall_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32), .MUL_LATENCY(ML)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_start    (ex_start),
    .ex_op       (ex_op),
    .ex_rs_data  (ex_rs_data),
    .ex_rt_data  (ex_rt_data),
    .flush       (flush),
    .stall_req   (stall_req),
    .md_valid    (md_valid),
    .md_hi       (md_hi),
    .md_lo       (md_lo),
    .div_by_zero (div_by_zero)
`ifdef MULDIV_STALL_CNT_EN
    ,
    .md_stall_cnt(md_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like MIPS.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edz, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0;
    if (op[1] == 1'b0) begin
      if (op == 2'b00) p = 64'(sa * sb);
      else             p = {32'h0, a} * {32'h0, b};
      eh = p[63:32]; el = p[31:0]; lat = ML + 1;
    end else if (b == 32'h0) begin
      eh = a; el = 32'hFFFF_FFFF; edz = 1'b1; lat = 1;
    end else begin
      if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
      else begin q = longint'({32'h0, a}) / longint'({32'h0, b});
                 r = longint'({32'h0, a}) % longint'({32'h0, b}); end
      p = 64'(q); el = p[31:0];
      p = 64'(r); eh = p[31:0];
      lat = 34;
    end
  endtask

  // Entered and left just after a rising edge. With gap=0, ex_start stays high
  // so the next call issues back-to-back.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit gap);
    logic [31:0] eh, el;
    logic edz;
    int lat, cyc, stalls;
    model(op, a, b, eh, el, edz, lat);
    ex_start = 1'b1; ex_op = op; ex_rs_data = a; ex_rt_data = b;
    cyc = 0; stalls = 0;
    @(negedge clk);
    while (md_valid !== 1'b1 && cyc < 100) begin
      if (stall_req === 1'b1) stalls++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_stalls"}, 64'(stalls), 64'(lat));
    chk({tag, "_stall_done"}, {63'h0, stall_req}, 64'h0);
    chk({tag, "_hilo"}, {md_hi, md_lo}, {eh, el});
    chk({tag, "_dz"}, {63'h0, div_by_zero}, {63'h0, edz});
    @(posedge clk); #1;
    if (gap) begin
      ex_start = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, {62'h0, md_valid, stall_req}, 64'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int pulses;
    logic [1:0]  op;
    logic [31:0] a, b;

    #12;
    chk("rst_hi", {32'h0, md_hi}, 64'h0);
    chk("rst_lo", {32'h0, md_lo}, 64'h0);
    chk("rst_valid", {63'h0, md_valid}, 64'h0);
    chk("rst_stall", {63'h0, stall_req}, 64'h0);
    chk("rst_dz", {63'h0, div_by_zero}, 64'h0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    do_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b1);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op("divu_zero", 2'b11, 32'h0000_1234, 32'h0, 1'b1);

    // Flush partway through a divide: no result may appear.
    ex_start = 1'b1; ex_op = 2'b11; ex_rs_data = 32'd5000; ex_rt_data = 32'd3;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1; ex_start = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'h0, stall_req, md_valid}, 64'h0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_valid === 1'b1 || stall_req === 1'b1) pulses++;
    end
    chk("flush_quiet", 64'(pulses), 64'h0);
    @(posedge clk); #1;
    do_op("multu_after_flush", 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);

    // Asynchronous reset in the middle of a divide.
    ex_start = 1'b1; ex_op = 2'b10; ex_rs_data = 32'h1234_5678; ex_rt_data = 32'd9;
    repeat (21) @(posedge clk);
    #2 rst = 1'b1; ex_start = 1'b0;
    #1;
    chk("arst_hilo", {md_hi, md_lo}, 64'h0);
    chk("arst_ctl", {61'h0, md_valid, stall_req, div_by_zero}, 64'h0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    do_op("b2b_mult", 2'b00, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
    do_op("b2b_divu", 2'b11, 32'hDEAD_BEEF, 32'd1000, 1'b1);
`ifdef MULDIV_STALL_CNT_EN
    chk("stall_cnt", {32'h0, md_stall_cnt}, 64'd36);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      do_op("rand", op, a, b, 1'($urandom_range(0, 1)));
    end
    ex_start = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the static MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs an iterative 32-step divider; multiply has a fixed latency.
- Holds `stall_req` high to freeze the IF/ID/EX/MEM pipeline registers until the 64-bit HI/LO result is ready.
- Presents the result for one cycle, to be carried through MEM_WB into the HI/LO write path.

Parameters:
- WIDTH, 32: operand width. Only 32 is supported.
- MUL_LATENCY, 1: cycles spent in MUL state, legal range 1..4. The product is registered at the end of the last MUL cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_start  in  1  EX holds a mul/div instruction
- ex_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- ex_rs_data  in  32  multiplicand / dividend
- ex_rt_data  in  32  multiplier / divisor
- flush  in  1  synchronous abort (exception/eret)
- stall_req  out  1  pipeline freeze request
- md_valid  out  1  result valid, one-cycle pulse
- md_hi  out  32  HI result (product[63:32] / remainder)
- md_lo  out  32  LO result (product[31:0] / quotient)
- div_by_zero  out  1  qualifies md_valid; divisor was 0

Behaviour:
- Reset: state IDLE, counter 0, md_hi/md_lo 0, md_valid 0, div_by_zero 0, internal operand/sign registers 0.
- stall_req is combinational, and is 1 when any of:
  - state==IDLE && ex_start && !flush
  - state is MUL, DIV_RUN or DIV_FIX
- stall_req is 0 in DONE.
- States: IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
- IDLE, on ex_start && !flush: latch operands, op and signs, then branch:
  - MULT/MULTU → MUL; counter = MUL_LATENCY-1.
  - DIV/DIVU with rt==0 → DONE; md_hi = rs, md_lo = 32'hFFFFFFFF, div_by_zero = 1.
  - DIV/DIVU otherwise → DIV_RUN; counter = 0.
  - Signed ops use absolute values; the quotient and remainder signs are saved.
- MUL:
  - Product is signed 64-bit for MULT, unsigned for MULTU.
  - When counter==0, register the product into md_hi/md_lo → DONE; else decrement the counter.
- DIV_RUN:
  - One restoring step per cycle: shift the remainder/quotient pair left 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - After 32 steps (counter==31) → DIV_FIX.
- DIV_FIX (signed ops only; unsigned values pass through) → DONE:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Results are written to md_lo (quotient) and md_hi (remainder).
- DONE:
  - md_valid=1 for this cycle; md_hi/md_lo held stable.
  - ex_start is ignored, because the same instruction advances out of EX this cycle.
  - → IDLE.
- md_hi/md_lo hold their last value outside DONE.
- Latency from the request cycle (first stall cycle) to the md_valid cycle:
  - MUL: MUL_LATENCY+1
  - Divide: 34
  - Divide by zero: 1
- Overflow case: 0x80000000 / 0xFFFFFFFF (DIV) → LO=0x80000000, HI=0, no flag.
- flush has priority over everything:
  - From any state → IDLE at the next edge; md_valid is not asserted and div_by_zero is cleared.
  - flush with ex_start in IDLE drops the request; stall_req=0 that cycle.
- Async reset mid-division aborts immediately with all outputs at reset values.

Optional Feature:
- MULDIV_STALL_CNT_EN, when defined:
  - Adds output `md_stall_cnt` [31:0], the count of cycles with stall_req=1.
  - Saturates at 32'hFFFFFFFF and is cleared only by rst.
- When not defined: the port and the counter are absent, with no other behavioural change.

Decomposition:
- Package `muldiv_pkg` holds:
  - op codes MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encoding (3-bit localparams)
  - DIV_STEPS=32
- Sub-module `div_core`:
  - Contents: iterative restoring divider datapath (remainder/quotient shift register, trial subtractor, step counter).
  - Controls: load and step inputs from muldiv_ctrl; sign fix stays in the parent.

Test Plan:
1. MULT rs=0xFFFFFFFE (-2), rt=3, MUL_LATENCY=1 → stall_req high 2 cycles; md_valid in cycle 2 with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. DIVU rs=100, rt=7 → stall_req 34 cycles; md_valid at cycle 34 with LO=14, HI=2, div_by_zero=0.
3. DIV rs=-7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
4. DIVU rs=0x1234, rt=0 → one stall cycle; md_valid with div_by_zero=1, HI=0x1234, LO=0xFFFFFFFF.
5. flush at DIV_RUN step 10 → next cycle IDLE, stall_req=0, no md_valid; a following MULTU 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE. Separately, assert rst at step 20 → outputs zero asynchronously.
6. Back-to-back MULT then DIVU with ex_start held through DONE → exactly two md_valid pulses, no duplicate issue. With MULDIV_STALL_CNT_EN defined, md_stall_cnt=2+34=36.
